srt_otf_quotient_reg: RTL and testbench

Parametrised quotient register for the radix-4 SRT divider, and the successor to the plain load-enable register. It accepts one signed radix-4 quotient digit per cycle in {-2..+2]. It performs on-the-fly conversion into two registers: Q (quotient) and QM (quotient minus one ulp). A digit counter tracks progress and flags completion. No carry-propagate adder is needed at the end of division.

---
 rtl/srt_otf_quotient_reg_if.sv | 33 +++
 rtl/srt_otf_quotient_reg.sv | 112 +++++++++++
 tb/tb_srt_otf_quotient_reg.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/srt_otf_quotient_reg_if.sv
// Digit/result bundle between the SRT digit-selection datapath and the quotient register.
// SRT_QSEL_CORR_EN adds rem_neg, the final remainder sign used for quotient correction.
interface srt_otf_quotient_reg_if #(
  parameter int WIDTH = 26
);
  logic             start;
  logic             digit_valid;
  logic [2:0]       digit;
`ifdef SRT_QSEL_CORR_EN
  logic             rem_neg;
`endif
  logic [WIDTH-1:0] q_out;
  logic [WIDTH-1:0] qm_out;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
`ifdef SRT_QSEL_CORR_EN
    output rem_neg,
`endif
    output start, digit_valid, digit,
    input  q_out, qm_out, busy, done, err
  );

  modport slave (
`ifdef SRT_QSEL_CORR_EN
    input  rem_neg,
`endif
    input  start, digit_valid, digit,
    output q_out, qm_out, busy, done, err
  );
endinterface

// File: rtl/srt_otf_quotient_reg.sv
// Radix-4 SRT quotient register with on-the-fly conversion into Q and QM = Q - 1.
// Optional macro SRT_QSEL_CORR_EN: q_out selects QM when the final remainder is negative.
module srt_otf_quotient_reg #(
  parameter int WIDTH = 26,
  parameter int NDIG  = 13
) (
  input logic                   clk,
  input logic                   resetn,
  srt_otf_quotient_reg_if.slave bus
);

  localparam int            CW   = $clog2(NDIG + 1);
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  // Codes 3'b011 (+3) and 3'b100 (-4) are outside the redundant digit set.
  function automatic logic digit_illegal(input logic [2:0] d);
    return (d == 3'b011) || (d == 3'b100);
  endfunction

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] qm_r;
  logic [CW-1:0]    count_r;
  logic             busy_r;
  logic             done_r;
  logic             err_r;
  logic [WIDTH-1:0] q_nxt_s;
  logic [WIDTH-1:0] qm_nxt_s;
  logic [2:0]       dig_s;
  logic             accept_s;
  logic             last_s;

  // Digit acceptance and on-the-fly Q/QM append selection
  always_comb begin
    accept_s = bus.digit_valid && busy_r && !bus.start;
    last_s   = accept_s && (count_r == LAST);
    dig_s    = digit_illegal(bus.digit) ? 3'b000 : bus.digit;
    q_nxt_s  = q_r;
    qm_nxt_s = qm_r;
    case (dig_s)
      3'b001, 3'b010: begin
        q_nxt_s  = {q_r[WIDTH-3:0], dig_s[1:0]};
        qm_nxt_s = {q_r[WIDTH-3:0], dig_s[1:0] - 2'b01};
      end
      // negative digits borrow from QM: low bits are (4+d) and (3+d)
      3'b111, 3'b110: begin
        q_nxt_s  = {qm_r[WIDTH-3:0], dig_s[1:0]};
        qm_nxt_s = {qm_r[WIDTH-3:0], dig_s[1:0] - 2'b01};
      end
      3'b000: begin
        q_nxt_s  = {q_r[WIDTH-3:0], 2'b00};
        qm_nxt_s = {qm_r[WIDTH-3:0], 2'b11};
      end
      default: begin
        q_nxt_s  = {q_r[WIDTH-3:0], 2'b00};
        qm_nxt_s = {qm_r[WIDTH-3:0], 2'b11};
      end
    endcase
  end

  // Quotient registers, digit counter and status flags
  always_ff @(posedge clk) begin
    if (!resetn) begin
      q_r     <= {WIDTH{1'b0}};
      qm_r    <= {WIDTH{1'b1}};
      count_r <= {CW{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else if (bus.start) begin
      q_r     <= {WIDTH{1'b0}};
      qm_r    <= {WIDTH{1'b1}};
      count_r <= {CW{1'b0}};
      busy_r  <= 1'b1;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else if (accept_s) begin
      q_r     <= q_nxt_s;
      qm_r    <= qm_nxt_s;
      count_r <= count_r + CW'(1'b1);
      if (last_s) begin
        busy_r <= 1'b0;
        done_r <= 1'b1;
      end
      if (digit_illegal(bus.digit)) begin
        err_r <= 1'b1;
      end
    end
  end

`ifdef SRT_QSEL_CORR_EN
  logic corr_r;

  // Remainder-sign flag: captured on the last digit and tracked while done
  always_ff @(posedge clk) begin
    if (!resetn || bus.start) begin
      corr_r <= 1'b0;
    end else if (last_s || done_r) begin
      corr_r <= bus.rem_neg;
    end
  end

  assign bus.q_out = (done_r && corr_r) ? qm_r : q_r;
`else
  assign bus.q_out = q_r;
`endif

  assign bus.qm_out = qm_r;
  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
  assign bus.err    = err_r;

endmodule

// File: tb/tb_srt_otf_quotient_reg.sv
// Scoreboard bench for srt_otf_quotient_reg: stimulus queues expectations, a negedge monitor checks them.
module tb_srt_otf_quotient_reg;
  localparam int WIDTH = 26;
  localparam int NDIG  = 13;
  localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  srt_otf_quotient_reg_if #(.WIDTH(WIDTH)) bus();

  srt_otf_quotient_reg #(.WIDTH(WIDTH), .NDIG(NDIG)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  typedef struct {
    string            name;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qm;
    logic             busy;
    logic             done;
    logic             err;
    int               cyc;
  } exp_t;

  exp_t snap_q[$];
  exp_t done_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  logic snap  = 1'b0;
  logic done_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input exp_t e, input bit timed);
    logic [2*WIDTH+2:0] act;
    logic [2*WIDTH+2:0] req;
    act = {bus.q_out, bus.qm_out, bus.busy, bus.done, bus.err};
    req = {e.q, e.qm, e.busy, e.done, e.err};
    n_cmp++;
    if ((act !== req) || (timed && (cyc != e.cyc))) begin
      n_err++;
      $display("FAIL %s: got q=%h qm=%h busy=%b done=%b err=%b cyc=%0d, want q=%h qm=%h busy=%b done=%b err=%b cyc=%0d",
               e.name, bus.q_out, bus.qm_out, bus.busy, bus.done, bus.err, cyc,
               e.q, e.qm, e.busy, e.done, e.err, timed ? e.cyc : cyc);
    end
  endtask

  // Monitor: snapshot requests and every rising edge of done pop an expectation
  initial begin
    forever begin
      @(negedge clk);
      if (snap) begin
        if (snap_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL snap_underflow: got a snapshot request, want a queued expectation");
        end else begin
          check(snap_q.pop_front(), 1'b0);
        end
      end
      if ((bus.done === 1'b1) && (done_prev !== 1'b1)) begin
        if (done_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_done: got done=1 at cyc=%0d, want done=0", cyc);
        end else begin
          check(done_q.pop_front(), 1'b1);
        end
      end
      done_prev = bus.done;
    end
  end

  task automatic drive(input logic s, input logic v, input logic [2:0] d);
    bus.start       = s;
    bus.digit_valid = v;
    bus.digit       = d;
    @(posedge clk);
    #1;
    snap = 1'b0;
  endtask

  task automatic digits(input logic [2:0] d, input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b1, d);
  endtask

  task automatic expect_snap(input string nm, input logic [WIDTH-1:0] q, input logic [WIDTH-1:0] qm,
                             input logic b, input logic dn, input logic e);
    exp_t x;
    x = '{name: nm, q: q, qm: qm, busy: b, done: dn, err: e, cyc: 0};
    snap_q.push_back(x);
    snap = 1'b1;
  endtask

  // k = number of digit cycles still to be driven, the last of which completes the division
  task automatic expect_done(input string nm, input logic [WIDTH-1:0] q, input logic [WIDTH-1:0] qm,
                             input logic e, input int k);
    exp_t x;
    x = '{name: nm, q: q, qm: qm, busy: 1'b0, done: 1'b1, err: e, cyc: cyc + k};
    done_q.push_back(x);
  endtask

  initial begin
    resetn          = 1'b0;
    bus.start       = 1'b0;
    bus.digit_valid = 1'b0;
    bus.digit       = 3'b000;
`ifdef SRT_QSEL_CORR_EN
    bus.rem_neg     = 1'b0;
`endif
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 3'b000);
    drive(1'b0, 1'b0, 3'b000);
    expect_snap("reset", 26'h0000000, ONES, 1'b0, 1'b0, 1'b0);
    resetn = 1'b1;

    // all-zero digits
    drive(1'b1, 1'b0, 3'b000);
    expect_snap("start", 26'h0000000, ONES, 1'b1, 1'b0, 1'b0);
    expect_done("zeros", 26'h0000000, 26'h3FFFFFF, 1'b0, 13);
    digits(3'b000, 13);
    drive(1'b0, 1'b0, 3'b000);

    // +1, -1, then zeros
    drive(1'b1, 1'b0, 3'b000);
    expect_done("pos_neg", 26'h0C00000, 26'h0BFFFFF, 1'b0, 13);
    digits(3'b001, 1);
    digits(3'b111, 1);
    digits(3'b000, 11);
    drive(1'b0, 1'b0, 3'b000);

    // negative first digit
    drive(1'b1, 1'b0, 3'b000);
    expect_done("neg_first", 26'h3000000, 26'h2FFFFFF, 1'b0, 13);
    digits(3'b111, 1);
    digits(3'b000, 12);
    drive(1'b0, 1'b0, 3'b000);

    // illegal code, then digits while done, then restart clears err
    drive(1'b1, 1'b0, 3'b000);
    digits(3'b100, 1);
    expect_snap("illegal_err", 26'h0000000, ONES, 1'b1, 1'b0, 1'b1);
    expect_done("illegal_done", 26'h0000000, ONES, 1'b1, 12);
    digits(3'b000, 12);
    digits(3'b010, 3);
    expect_snap("idle_digits", 26'h0000000, ONES, 1'b0, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 3'b000);
    expect_snap("restart_clears_err", 26'h0000000, ONES, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 3'b000);

    // restart mid-division with a colliding digit
    drive(1'b1, 1'b0, 3'b000);
    digits(3'b010, 5);
    expect_snap("five_twos", 26'h00002AA, 26'h00002A9, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 3'b010);
    expect_snap("collision", 26'h0000000, ONES, 1'b1, 1'b0, 1'b0);
    expect_done("twos", 26'h2AAAAAA, 26'h2AAAAA9, 1'b0, 13);
    digits(3'b010, 13);
    drive(1'b0, 1'b0, 3'b000);

    // reset mid-division
    drive(1'b1, 1'b0, 3'b000);
    digits(3'b001, 4);
    resetn = 1'b0;
    drive(1'b0, 1'b1, 3'b001);
    expect_snap("midreset", 26'h0000000, ONES, 1'b0, 1'b0, 1'b0);
    resetn = 1'b1;
    drive(1'b0, 1'b0, 3'b000);
    drive(1'b0, 1'b1, 3'b010);
    expect_snap("post_reset_idle", 26'h0000000, ONES, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 3'b000);

`ifdef SRT_QSEL_CORR_EN
    // negative final remainder selects QM while done
    drive(1'b1, 1'b0, 3'b000);
    expect_done("corr_neg", 26'h0BFFFFF, 26'h0BFFFFF, 1'b0, 13);
    digits(3'b001, 1);
    digits(3'b111, 1);
    digits(3'b000, 10);
    bus.rem_neg = 1'b1;
    digits(3'b000, 1);
    drive(1'b0, 1'b0, 3'b000);
    expect_snap("corr_hold", 26'h0BFFFFF, 26'h0BFFFFF, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 3'b000);
    expect_snap("corr_cleared", 26'h0000000, ONES, 1'b1, 1'b0, 1'b0);
    bus.rem_neg = 1'b0;
    drive(1'b0, 1'b0, 3'b000);
`endif

    drive(1'b0, 1'b0, 3'b000);
    drive(1'b0, 1'b0, 3'b000);
    if ((snap_q.size() != 0) || (done_q.size() != 0)) begin
      n_cmp++; n_err++;
      $display("FAIL leftovers: got %0d snapshot and %0d done expectations unconsumed, want 0 and 0",
               snap_q.size(), done_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
